// File: rtl/alu_uart_ctrl_pkg.sv
// Shared definitions: ALU opcode values and the sequencer FSM state encoding.
package alu_uart_ctrl_pkg;

    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_XOR = 6'b100110;
    localparam logic [5:0] ALU_SRL = 6'b000010;
    localparam logic [5:0] ALU_SRA = 6'b000011;
    localparam logic [5:0] ALU_NOR = 6'b100111;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; undefined opcodes produce zero.
module alu
    import alu_uart_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int OP_SIZE   = 6
) (
    input  logic [DATA_SIZE-1:0] i_a,
    input  logic [DATA_SIZE-1:0] i_b,
    input  logic [OP_SIZE-1:0]   i_op,
    output logic [DATA_SIZE-1:0] o_result
);

    // Opcode decode into the selected operation.
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_SRL: o_result = i_a >> i_b;
            ALU_SRA: o_result = $signed(i_a) >>> i_b;
            ALU_NOR: o_result = ~(i_a | i_b);
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Sequencer between UART RX/TX and the ALU: collects A, B, opcode,
// samples the ALU result one cycle later and sends it back over TX.
module alu_uart_ctrl
    import alu_uart_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int OP_SIZE   = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_done,
    input  logic [DATA_SIZE-1:0] i_rx_data,
    input  logic                 i_tx_done,
    input  logic [DATA_SIZE-1:0] i_alu_result,
    output logic [DATA_SIZE-1:0] o_alu_a,
    output logic [DATA_SIZE-1:0] o_alu_b,
    output logic [OP_SIZE-1:0]   o_alu_op,
    output logic                 o_tx_start,
    output logic [DATA_SIZE-1:0] o_tx_data,
    output logic                 o_busy
);

    ctrl_state_t state;
    ctrl_state_t state_next;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= WAIT_A;
        else         state <= state_next;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state;
        o_tx_start = 1'b0;
        o_busy     = 1'b0;
        case (state)
            WAIT_A:  if (i_rx_done) state_next = WAIT_B;
            WAIT_B:  if (i_rx_done) state_next = WAIT_OP;
            WAIT_OP: if (i_rx_done) state_next = EXEC;
            EXEC: begin
                o_busy     = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                o_busy     = 1'b1;
                o_tx_start = 1'b1;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                o_busy = 1'b1;
                // A coincident rx byte is deliberately dropped here.
                if (i_tx_done) state_next = WAIT_A;
            end
            default: state_next = WAIT_A;
        endcase
    end

    // Operand/opcode capture during collection and result capture in EXEC.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
        end else begin
            case (state)
                WAIT_A:  if (i_rx_done) o_alu_a  <= i_rx_data;
                WAIT_B:  if (i_rx_done) o_alu_b  <= i_rx_data;
                WAIT_OP: if (i_rx_done) o_alu_op <= i_rx_data[OP_SIZE-1:0];
                EXEC:    o_tx_data <= i_alu_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Bench for alu_uart_ctrl wired to the ALU; expected TX bytes go through a
// scoreboard queue and are compared whenever the DUT pulses o_tx_start.
module tb_alu_uart_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned starts = 0;
    int unsigned starts_exp = 0;
    logic [7:0]  sb[$];
    logic [7:0]  sb_exp;

    always #5 clk = ~clk;

    alu_uart_ctrl #(.DATA_SIZE(8), .OP_SIZE(6)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_tx_done    (tx_done),
        .i_alu_result (alu_result),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_busy       (busy)
    );

    alu #(.DATA_SIZE(8), .OP_SIZE(6)) u_alu (
        .i_a      (alu_a),
        .i_b      (alu_b),
        .i_op     (alu_op),
        .o_result (alu_result)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20: ref_alu = a + b;
            6'h22: ref_alu = a - b;
            6'h24: ref_alu = a & b;
            6'h25: ref_alu = a | b;
            6'h26: ref_alu = a ^ b;
            6'h02: ref_alu = a >> b;
            6'h03: ref_alu = $signed(a) >>> b;
            6'h27: ref_alu = ~(a | b);
            default: ref_alu = 8'h00;
        endcase
    endfunction

    // Scoreboard: every TX start pops one expected byte.
    always @(negedge clk) begin
        if (tx_start) begin
            starts++;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_exp = sb.pop_front();
                check("tx_data", {24'd0, tx_data}, {24'd0, sb_exp});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input bit stray_rx, input bit both);
        int unsigned n;
        send_byte(a);
        check("alu_a", {24'd0, alu_a}, {24'd0, a});
        send_byte(b);
        check("alu_b", {24'd0, alu_b}, {24'd0, b});
        sb.push_back(ref_alu(a, b, opb[5:0]));
        starts_exp++;
        send_byte(opb);
        check("alu_op", {26'd0, alu_op}, {26'd0, opb[5:0]});
        check("busy_exec", {31'd0, busy}, 32'd1);
        n = 0;
        while (!tx_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("tx_latency", n, 32'd1);
        @(negedge clk);
        check("tx_pulse_width", {31'd0, tx_start}, 32'd0);
        check("busy_wait_tx", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        if (stray_rx) begin
            rx_done = 1'b1;
            rx_data = 8'h77;
            tx_done = both;
            @(negedge clk);
            rx_done = 1'b0;
            tx_done = 1'b0;
            check("busy_after_stray", {31'd0, busy}, {31'd0, !both});
        end
        if (!(stray_rx && both)) begin
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("alu_a_hold", {24'd0, alu_a}, {24'd0, a});
    endtask

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_alu_a", {24'd0, alu_a}, 32'd0);

        run_op(8'h05, 8'h03, 8'h20, 1'b0, 1'b0);   // ADD -> 08
        run_op(8'h03, 8'h05, 8'h22, 1'b0, 1'b0);   // SUB -> FE
        run_op(8'h80, 8'h02, 8'h03, 1'b0, 1'b0);   // SRA -> E0
        run_op(8'hF0, 8'h3C, 8'hE4, 1'b0, 1'b0);   // AND via masked opcode -> 30
        run_op(8'h42, 8'h11, 8'h26, 1'b1, 1'b0);   // XOR, stray rx in WAIT_TX
        run_op(8'h11, 8'h22, 8'h25, 1'b1, 1'b1);   // OR, rx+tx done together
        run_op(8'h0F, 8'h01, 8'h27, 1'b0, 1'b0);   // NOR -> F0

        // Mid-sequence reset discards partial operands.
        send_byte(8'h05);
        send_byte(8'h03);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_alu_a", {24'd0, alu_a}, 32'd0);
        check("mid_rst_alu_b", {24'd0, alu_b}, 32'd0);
        check("mid_rst_alu_op", {26'd0, alu_op}, 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        run_op(8'h01, 8'h02, 8'h20, 1'b0, 1'b0);   // ADD -> 03

        // Undefined opcode still transmits, with a zero result.
        run_op(8'hAA, 8'h55, 8'h3F, 1'b0, 1'b0);

        // Stray tx_done while idle must not start anything.
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("stray_tx_busy", {31'd0, busy}, 32'd0);
        run_op(8'h09, 8'h04, 8'h22, 1'b0, 1'b0);   // SUB -> 05

        repeat (3) @(negedge clk);
        check("tx_start_count", starts, starts_exp);
        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
